// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter onto a single peripheral bus.
// Master 0 is instruction fetch and master 1 is the load/store unit.
// Each transfer runs IDLE -> BUSY -> DONE -> GAP.
//
// Handshake: a master raises mN_read and/or mN_write with stable
// addr/wdata/byte_size and holds them until it sees mN_ready. A request
// with both strobes set is a write. mN_ready is a single-cycle pulse. In
// that same cycle mN_err, mN_rdata and read_ready describe the result.
// The slave answers a bus request by pulsing io_ready while io_read or
// io_write is high. io_ready at any other time carries no meaning.
module periph_bus_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [1:0]      m0_byte_size,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_ready,
  output logic            m0_err,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [1:0]      m1_byte_size,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_ready,
  output logic            m1_err,
  output logic [XLEN-1:0] io_addr,
  output logic [XLEN-1:0] io_wdata,
  output logic            io_read,
  output logic            io_write,
  output logic [1:0]      io_byte_size,
  input  logic [XLEN-1:0] io_rdata,
  input  logic            io_ready,
  output logic            read_ready,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Last BUSY cycle index before giving up on the slave
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        grant;       // 0 = m0, 1 = m1 for the transfer in flight
  logic        last_grant;  // winner of the previous grant, for round-robin
  logic        bus_write;   // latched direction of the transfer in flight
  logic [15:0] wait_cnt;

  logic            req0;
  logic            req1;
  logic            pick_m1;
  logic            finish;
  logic [XLEN-1:0] cap_data;

  assign dbg_state = state;

  // Request decode, round-robin pick and completion data selection
  always_comb begin
    req0     = m0_read | m0_write;
    req1     = m1_read | m1_write;
    pick_m1  = req1 && (!req0 || !last_grant);
    finish   = io_ready || (wait_cnt == WAIT_LAST);
    cap_data = '0;
    if (io_ready && !bus_write) begin
      cap_data = io_rdata;
    end
  end

  // Transfer sequencer: all bus and response outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      bus_write    <= 1'b0;
      wait_cnt     <= 16'd0;
      io_addr      <= '0;
      io_wdata     <= '0;
      io_byte_size <= 2'd0;
      io_read      <= 1'b0;
      io_write     <= 1'b0;
      read_ready   <= 1'b0;
      m0_rdata     <= '0;
      m0_ready     <= 1'b0;
      m0_err       <= 1'b0;
      m1_rdata     <= '0;
      m1_ready     <= 1'b0;
      m1_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            grant      <= pick_m1;
            last_grant <= pick_m1;
            wait_cnt   <= 16'd0;
            state      <= ST_BUSY;
            if (pick_m1) begin
              bus_write    <= m1_write;
              io_write     <= m1_write;
              io_read      <= !m1_write;
              io_addr      <= m1_addr;
              io_wdata     <= m1_wdata;
              io_byte_size <= m1_byte_size;
            end else begin
              bus_write    <= m0_write;
              io_write     <= m0_write;
              io_read      <= !m0_write;
              io_addr      <= m0_addr;
              io_wdata     <= m0_wdata;
              io_byte_size <= m0_byte_size;
            end
          end
        end
        ST_BUSY: begin
          if (finish) begin
            io_read    <= 1'b0;
            io_write   <= 1'b0;
            read_ready <= io_ready && !bus_write;
            state      <= ST_DONE;
            if (grant) begin
              m1_rdata <= cap_data;
              m1_ready <= 1'b1;
              m1_err   <= !io_ready;
            end else begin
              m0_rdata <= cap_data;
              m0_ready <= 1'b1;
              m0_err   <= !io_ready;
            end
          end else begin
            wait_cnt <= 16'(wait_cnt + 16'd1);
          end
        end
        ST_DONE: begin
          m0_ready   <= 1'b0;
          m0_err     <= 1'b0;
          m1_ready   <= 1'b0;
          m1_err     <= 1'b0;
          read_ready <= 1'b0;
          state      <= ST_GAP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized bench for periph_bus_arbiter with a transaction-level model.
// The model predicts the grant order, how many cycles the bus strobe stays
// high, and the response each master should see.
module tb_periph_bus_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [XLEN-1:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic            m0_read, m0_write, m0_ready, m0_err;
  logic            m1_read, m1_write, m1_ready, m1_err;
  logic [1:0]      m0_byte_size, m1_byte_size, io_byte_size, dbg_state;
  logic [XLEN-1:0] io_addr, io_wdata, io_rdata;
  logic            io_read, io_write, io_ready, read_ready;

  periph_bus_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byte_size(m0_byte_size), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byte_size(m1_byte_size), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_read(io_read), .io_write(io_write),
    .io_byte_size(io_byte_size), .io_rdata(io_rdata), .io_ready(io_ready),
    .read_ready(read_ready), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // Pending request description per master
  logic            rq_rd[2];
  logic            rq_wr[2];
  logic [XLEN-1:0] rq_addr[2];
  logic [XLEN-1:0] rq_wdata[2];
  logic [XLEN-1:0] rq_data[2];   // data the slave returns for this transfer
  logic [1:0]      rq_size[2];
  int              rq_lat[2];    // BUSY cycle index where the slave answers
  int              rq_drop[2];   // BUSY cycle index where the master lets go, -1 = never

  // Reference model: previous winner, and what each rdata port should hold
  int              mdl_last;
  logic [XLEN-1:0] exp_rdata[2];
  logic [0:0]      exp_q[$];     // expected grant order

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int m);
    if (m == 0) begin
      m0_read = rq_rd[0]; m0_write = rq_wr[0]; m0_addr = rq_addr[0];
      m0_wdata = rq_wdata[0]; m0_byte_size = rq_size[0];
    end else begin
      m1_read = rq_rd[1]; m1_write = rq_wr[1]; m1_addr = rq_addr[1];
      m1_wdata = rq_wdata[1]; m1_byte_size = rq_size[1];
    end
  endtask

  task automatic clear_req(input int m);
    if (m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
    else begin m1_read = 1'b0; m1_write = 1'b0; end
  endtask

  // Outside a bus transfer the slave drives junk that must be ignored
  task automatic slave_noise();
    io_ready = 1'($urandom_range(0, 1));
    io_rdata = $urandom;
  endtask

  task automatic set_req(input int m, input logic rd, input logic wr, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] wdata, input logic [1:0] size,
                         input logic [XLEN-1:0] data, input int lat, input int drop);
    rq_rd[m] = rd; rq_wr[m] = wr; rq_addr[m] = addr; rq_wdata[m] = wdata;
    rq_size[m] = size; rq_data[m] = data; rq_lat[m] = lat; rq_drop[m] = drop;
  endtask

  task automatic rand_req(input int m);
    int op;
    op = $urandom_range(0, 2);  // 0 read, 1 write, 2 both strobes (a write)
    set_req(m, op != 1, op != 0, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, TO + 1), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1);
  endtask

  // Follow one transfer of master m from grant to the IDLE after GAP
  task automatic serve(input int m);
    int   waited;
    int   k;
    int   exp_busy;
    logic exp_to;
    waited = 0;
    while (!(io_read || io_write) && waited < 8) begin
      check("idle_ready", {m1_ready, m0_ready}, 2'b00);
      slave_noise();
      @(negedge clk);
      waited++;
    end
    if (!(io_read || io_write)) begin
      check("grant_seen", 1'b0, 1'b1);
      clear_req(m);
      return;
    end
    k = 0;
    while ((io_read || io_write) && k < 20) begin
      check("io_write", io_write, rq_wr[m]);
      check("io_read", io_read, !rq_wr[m]);
      check("io_addr", io_addr, rq_addr[m]);
      check("io_wdata", io_wdata, rq_wdata[m]);
      check("io_size", io_byte_size, rq_size[m]);
      check("busy_resp", {m1_ready, m0_ready, read_ready}, 3'b000);
      io_ready = (k == rq_lat[m]);
      io_rdata = (k == rq_lat[m]) ? rq_data[m] : $urandom;
      if (k == rq_drop[m]) clear_req(m);
      k++;
      @(negedge clk);
    end
    // DONE cycle
    exp_to       = (rq_lat[m] >= TO);
    exp_busy     = exp_to ? TO : rq_lat[m] + 1;
    exp_rdata[m] = (exp_to || rq_wr[m]) ? '0 : rq_data[m];
    check("busy_cycles", k, exp_busy);
    check("ready_granted", (m != 0) ? m1_ready : m0_ready, 1'b1);
    check("ready_other", (m != 0) ? m0_ready : m1_ready, 1'b0);
    check("err_granted", (m != 0) ? m1_err : m0_err, exp_to);
    check("err_other", (m != 0) ? m0_err : m1_err, 1'b0);
    check("rdata_m0", m0_rdata, exp_rdata[0]);
    check("rdata_m1", m1_rdata, exp_rdata[1]);
    check("read_ready", read_ready, !exp_to && !rq_wr[m]);
    clear_req(m);
    slave_noise();
    @(negedge clk);
    // GAP cycle
    check("gap_quiet", {m0_ready, m1_ready, m0_err, m1_err, read_ready, io_read, io_write}, 7'd0);
    check("gap_rdata_m0", m0_rdata, exp_rdata[0]);
    check("gap_rdata_m1", m1_rdata, exp_rdata[1]);
    slave_noise();
    @(negedge clk);
    mdl_last = m;
  endtask

  // Raise the requests in mask (bit0 m0, bit1 m1) and follow them to completion
  task automatic issue(input int mask);
    int m;
    if (mask[0]) drive_req(0);
    if (mask[1]) drive_req(1);
    if (mask == 3) begin
      m = (mdl_last == 1) ? 0 : 1;
      exp_q.push_back(1'(m));
      exp_q.push_back(1'(1 - m));
    end else begin
      exp_q.push_back(1'(mask == 2));
    end
    while (exp_q.size() > 0) begin
      m = int'(exp_q.pop_front());
      serve(m);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_io"}, {io_read, io_write, io_byte_size, io_addr, io_wdata}, '0);
    check({tag, "_m0"}, {m0_ready, m0_err, m0_rdata}, '0);
    check({tag, "_m1"}, {m1_ready, m1_err, m1_rdata}, '0);
    check({tag, "_read_ready"}, read_ready, 1'b0);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    rst_n = 1'b0;
    m0_addr = '0; m0_wdata = '0; m0_read = 1'b0; m0_write = 1'b0; m0_byte_size = 2'd0;
    m1_addr = '0; m1_wdata = '0; m1_read = 1'b0; m1_write = 1'b0; m1_byte_size = 2'd0;
    io_rdata = '0; io_ready = 1'b0;
    mdl_last = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // m0 read, slave answers in the second BUSY cycle
    set_req(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 2'd2, 32'hCAFE_0129, 1, -1);
    issue(1);

    // Reset while m0 is in BUSY, then the held request completes cleanly
    set_req(0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 2'd1, 32'h1234_5678, 9, -1);
    drive_req(0);
    io_ready = 1'b0;
    waited = 0;
    while (!(io_read || io_write) && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("pre_reset_busy", io_read, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    rst_n = 1'b1;
    mdl_last = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rq_lat[0] = 0;
    serve(0);

    // m1 write, slave answers at once
    set_req(1, 1'b0, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 2'd2, 32'h5555_AAAA, 0, -1);
    issue(2);
    // m0 read that times out, then a normal m0 read
    set_req(0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 2'd0, 32'h7777_0000, 9, -1);
    issue(1);
    set_req(0, 1'b1, 1'b0, 32'h0000_3004, 32'h0, 2'd2, 32'h7777_0004, 2, -1);
    issue(1);
    // Contention: m1 wins, drops its request one cycle into BUSY, m0 follows
    set_req(1, 1'b1, 1'b1, 32'h1000_0010, 32'h0BAD_F00D, 2'd1, 32'h1, 2, 1);
    set_req(0, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 2'd2, 32'h4444_4444, 1, -1);
    issue(3);
    // Repeated contention alternates
    for (int i = 0; i < 4; i++) begin
      rand_req(0);
      rand_req(1);
      issue(3);
    end
    // Random traffic
    for (int i = 0; i < 80; i++) begin
      rand_req(0);
      rand_req(1);
      issue($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
